// File: rtl/add_collect_pkg.sv
// Shared types and helpers for the adder result collector.
package add_collect_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int MISMATCH_W = 16;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

  // Expected adder result: carry out of the top bit is dropped.
  function automatic logic [DEF_DATA_W-1:0] exp_sum(input logic [DEF_DATA_W-1:0] a,
                                                    input logic [DEF_DATA_W-1:0] b);
    return a + b;
  endfunction

endpackage

// File: rtl/exp_delay_line.sv
// LATENCY-deep valid+data shift register that aligns expected values with the DUT result.
module exp_delay_line #(
  parameter int LATENCY = 1,
  parameter int W       = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_v_i,
  input  logic [W-1:0] in_d_i,
  output logic         out_v_o,
  output logic [W-1:0] out_d_o,
  output logic         any_v_o
);

  logic [LATENCY-1:0] v_q;
  logic [W-1:0]       d_q [LATENCY];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      for (int k = 0; k < LATENCY; k++) d_q[k] <= '0;
    end else begin
      v_q[0] <= in_v_i;
      d_q[0] <= in_d_i;
      for (int k = 1; k < LATENCY; k++) begin
        v_q[k] <= v_q[k-1];
        d_q[k] <= d_q[k-1];
      end
    end
  end

  assign out_v_o = v_q[LATENCY-1];
  assign out_d_o = d_q[LATENCY-1];
  assign any_v_o = |v_q;

endmodule

// File: rtl/add_result_collector.sv
// Checks DUT adder results against the operand sum and packs them into handshaked frames.
//   state     | meaning
//   OUT_EMPTY | no completed frame waiting for the consumer
//   OUT_FULL  | frame_data/frame_err hold a frame not yet accepted
module add_result_collector
  import add_collect_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int LATENCY   = 1,
  parameter int FRAME_LEN = 100
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  input  logic [DATA_W-1:0]             in_a,
  input  logic [DATA_W-1:0]             in_b,
  input  logic [DATA_W-1:0]             dut_res,
  output logic                          frame_valid,
  input  logic                          frame_ready,
  output logic [FRAME_LEN*DATA_W-1:0]   frame_data,
  output logic                          frame_err,
  output logic [MISMATCH_W-1:0]         mismatch_cnt,
  output logic                          overflow,
  output logic                          busy
);

  localparam int FW    = FRAME_LEN * DATA_W;
  localparam int IDX_W = $clog2(FRAME_LEN);

  logic [DATA_W-1:0]     exp_in, s_exp;
  logic                  s_v, pipe_busy;
  logic                  mism, last, accept, load;
  out_state_e            state_q, state_d;
  logic [FW-1:0]         asm_q, asm_d, fdata_q, fdata_d;
  logic [IDX_W-1:0]      fill_idx_q, fill_idx_d;
  logic                  aerr_q, aerr_d, ferr_q, ferr_d, ovf_q, ovf_d;
  logic [MISMATCH_W-1:0] mis_cnt_q, mis_cnt_d;

  assign exp_in = exp_sum(in_a, in_b);

  exp_delay_line #(.LATENCY(LATENCY), .W(DATA_W)) u_dly (
    .clk     (clk),
    .rst_n   (reset),
    .in_v_i  (in_valid),
    .in_d_i  (exp_in),
    .out_v_o (s_v),
    .out_d_o (s_exp),
    .any_v_o (pipe_busy)
  );

  assign mism = s_v && (s_exp != dut_res);
  assign last = s_v && (fill_idx_q == IDX_W'(FRAME_LEN-1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= OUT_EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      OUT_EMPTY: if (last) state_d = OUT_FULL;
      OUT_FULL:  if (accept && !last) state_d = OUT_EMPTY;
      default:   state_d = OUT_EMPTY;
    endcase
  end

  // An accept in the completion cycle frees the slot for the new frame.
  always_comb begin
    frame_valid = (state_q == OUT_FULL);
    accept      = frame_valid && frame_ready;
    load        = last && (!frame_valid || frame_ready);
  end

  always_comb begin
    asm_d      = asm_q;
    fill_idx_d = fill_idx_q;
    aerr_d     = aerr_q;
    mis_cnt_d  = mis_cnt_q;
    if (s_v) begin
      asm_d[fill_idx_q*DATA_W +: DATA_W] = dut_res;
      fill_idx_d = last ? '0 : fill_idx_q + IDX_W'(1);
      aerr_d     = last ? 1'b0 : (aerr_q | mism);
    end
    if (mism && (mis_cnt_q != '1)) mis_cnt_d = mis_cnt_q + MISMATCH_W'(1);
    fdata_d = load ? asm_d : fdata_q;
    ferr_d  = load ? (aerr_q | mism) : ferr_q;
    ovf_d   = ovf_q | (last && !load);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      asm_q      <= '0;
      fill_idx_q <= '0;
      aerr_q     <= 1'b0;
      mis_cnt_q  <= '0;
      fdata_q    <= '0;
      ferr_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      asm_q      <= asm_d;
      fill_idx_q <= fill_idx_d;
      aerr_q     <= aerr_d;
      mis_cnt_q  <= mis_cnt_d;
      fdata_q    <= fdata_d;
      ferr_q     <= ferr_d;
      ovf_q      <= ovf_d;
    end
  end

  assign frame_data   = fdata_q;
  assign frame_err    = ferr_q;
  assign mismatch_cnt = mis_cnt_q;
  assign overflow     = ovf_q;
  assign busy         = pipe_busy || (fill_idx_q != '0);

endmodule

// File: tb/tb_add_result_collector.sv
// Bench for add_result_collector: two instances (latency 1 and 3) against a frame-level model.
module tb_add_result_collector;

  localparam int W  = 8;
  localparam int N  = 100;
  localparam int FW = N * W;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic in_valid = 1'b0;
  logic [7:0] in_a = '0, in_b = '0;
  logic corrupt = 1'b0;
  logic frame_ready = 1'b0;

  logic [7:0]    xh [8];
  logic [7:0]    dres [2];
  logic          fv [2], ferr [2], ovf [2], busy [2];
  logic [FW-1:0] fd [2];
  logic [15:0]   mcnt [2];

  always #5 clk = ~clk;

  // Emulated adder under test: registered sum, optionally forced to zero.
  always @(posedge clk) begin
    xh[0] <= corrupt ? 8'h00 : 8'(in_a + in_b);
    for (int k = 1; k < 8; k++) xh[k] <= xh[k-1];
  end
  assign dres[0] = xh[0];
  assign dres[1] = xh[2];

  add_result_collector #(.DATA_W(8), .LATENCY(1), .FRAME_LEN(N)) u1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
    .dut_res(dres[0]), .frame_valid(fv[0]), .frame_ready(frame_ready),
    .frame_data(fd[0]), .frame_err(ferr[0]), .mismatch_cnt(mcnt[0]),
    .overflow(ovf[0]), .busy(busy[0]));

  add_result_collector #(.DATA_W(8), .LATENCY(3), .FRAME_LEN(N)) u3 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
    .dut_res(dres[1]), .frame_valid(fv[1]), .frame_ready(frame_ready),
    .frame_data(fd[1]), .frame_err(ferr[1]), .mismatch_cnt(mcnt[1]),
    .overflow(ovf[1]), .busy(busy[1]));

  // Model state: per-instance issue history, assembly, and presented frame.
  bit         mv [2][8];
  logic [7:0] md [2][8];
  bit         mm [2][8];
  logic [7:0] m_asm [2][N];
  logic [7:0] m_frame [2][N];
  int         m_cnt [2];
  bit         m_pend [2], m_ferr [2], m_aerr [2], m_ovf [2];
  int         m_mis [2];

  int total = 0;
  int bad = 0;
  int fcount [2];
  logic [FW-1:0] cap [2];

  function automatic int lat(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 8; k++) begin mv[i][k] = 0; md[i][k] = '0; mm[i][k] = 0; end
      for (int k = 0; k < N; k++) begin m_asm[i][k] = '0; m_frame[i][k] = '0; end
      m_cnt[i] = 0; m_pend[i] = 0; m_ferr[i] = 0; m_aerr[i] = 0; m_ovf[i] = 0; m_mis[i] = 0;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      int L = lat(i);
      bit acc, sv, sm, loaded;
      logic [7:0] sd;
      acc = m_pend[i] && frame_ready;
      sv = mv[i][L-1]; sd = md[i][L-1]; sm = mm[i][L-1];
      for (int k = 7; k > 0; k--) begin
        mv[i][k] = mv[i][k-1]; md[i][k] = md[i][k-1]; mm[i][k] = mm[i][k-1];
      end
      mv[i][0] = in_valid;
      md[i][0] = corrupt ? 8'h00 : 8'(in_a + in_b);
      mm[i][0] = (md[i][0] != 8'(in_a + in_b));
      loaded = 0;
      if (sv) begin
        m_asm[i][m_cnt[i]] = sd;
        if (sm) begin
          m_aerr[i] = 1;
          if (m_mis[i] < 65535) m_mis[i]++;
        end
        m_cnt[i]++;
        if (m_cnt[i] == N) begin
          m_cnt[i] = 0;
          if (!m_pend[i] || acc) begin
            for (int k = 0; k < N; k++) m_frame[i][k] = m_asm[i][k];
            m_ferr[i] = m_aerr[i];
            m_pend[i] = 1;
            loaded = 1;
          end else begin
            m_ovf[i] = 1;
          end
          m_aerr[i] = 0;
        end
      end
      if (acc && !loaded) m_pend[i] = 0;
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      bit mb, ok;
      mb = (m_cnt[i] != 0);
      for (int k = 0; k < lat(i); k++) mb |= mv[i][k];
      chk($sformatf("frame_valid[%0d]", i), 32'(fv[i]), 32'(m_pend[i]));
      chk($sformatf("frame_err[%0d]", i), 32'(ferr[i]), 32'(m_ferr[i]));
      chk($sformatf("mismatch_cnt[%0d]", i), 32'(mcnt[i]), 32'(m_mis[i]));
      chk($sformatf("overflow[%0d]", i), 32'(ovf[i]), 32'(m_ovf[i]));
      chk($sformatf("busy[%0d]", i), 32'(busy[i]), 32'(mb));
      ok = 1;
      for (int k = 0; k < N; k++) if (fd[i][k*8 +: 8] !== m_frame[i][k]) ok = 0;
      chk($sformatf("frame_data[%0d]", i), 32'(ok), 32'd1);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) model_step();
    @(negedge clk);
    if (reset) begin
      compare_all();
      for (int i = 0; i < 2; i++) if (fv[i]) begin fcount[i]++; cap[i] = fd[i]; end
    end
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic c);
    in_valid = 1'b1; in_a = a; in_b = b; corrupt = c;
    tick();
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0; corrupt = 1'b0;
    repeat (n) tick();
  endtask

  task automatic do_reset();
    in_valid = 1'b0; corrupt = 1'b0;
    reset = 1'b0;
    model_clear();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    model_clear();
    fcount[0] = 0; fcount[1] = 0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_frame_valid", 32'(fv[i]), 0);
      chk("rst_mismatch_cnt", 32'(mcnt[i]), 0);
      chk("rst_overflow", 32'(ovf[i]), 0);
      chk("rst_busy", 32'(busy[i]), 0);
      chk("rst_frame_data", 32'(fd[i] == '0), 1);
    end
    reset = 1'b1;

    // Basic frame, ready always high.
    frame_ready = 1'b1;
    for (int k = 0; k < N; k++) send(8'(k), 8'(2*k), 1'b0);
    chk("basic_lat_pre", 32'(fv[0]), 0);
    in_valid = 1'b0;
    tick();
    chk("basic_lat_post", 32'(fv[0]), 1);
    chk("basic_byte99", 32'(fd[0][99*8 +: 8]), 32'h29);
    chk("basic_byte50", 32'(fd[0][50*8 +: 8]), 32'h96);
    chk("basic_err", 32'(ferr[0]), 0);
    idle(5);
    chk("basic_count_l1", fcount[0], 1);
    chk("basic_count_l3", fcount[1], 1);
    chk("basic_mis_l3", 32'(mcnt[1]), 0);

    // Carry wrap with a forced bad result on pair 5.
    fcount[0] = 0; fcount[1] = 0;
    for (int k = 0; k < N; k++) send(8'hFF, 8'h02, k == 5);
    in_valid = 1'b0; corrupt = 1'b0;
    tick();
    chk("wrap_valid", 32'(fv[0]), 1);
    chk("wrap_byte5", 32'(fd[0][5*8 +: 8]), 32'h00);
    chk("wrap_byte6", 32'(fd[0][6*8 +: 8]), 32'h01);
    chk("wrap_err", 32'(ferr[0]), 1);
    chk("wrap_mis", 32'(mcnt[0]), 1);
    idle(5);
    chk("wrap_mis_l3", 32'(mcnt[1]), 1);
    chk("wrap_count_l3", fcount[1], 1);

    // Backpressure through two bursts.
    frame_ready = 1'b0;
    for (int k = 0; k < N; k++) send(8'(k), 8'(k+1), 1'b0);
    idle(5);
    chk("bp_valid", 32'(fv[0]), 1);
    chk("bp_ovf_first", 32'(ovf[0]), 0);
    for (int k = 0; k < N; k++) send(8'(k), 8'h05, 1'b0);
    idle(5);
    chk("bp_ovf_l1", 32'(ovf[0]), 1);
    chk("bp_ovf_l3", 32'(ovf[1]), 1);
    chk("bp_hold_byte10", 32'(fd[0][10*8 +: 8]), 32'h15);
    frame_ready = 1'b1;
    tick();
    frame_ready = 1'b0;
    chk("bp_drop_l1", 32'(fv[0]), 0);
    chk("bp_drop_l3", 32'(fv[1]), 0);
    idle(2);

    // Accept in the same cycle the second frame completes.
    do_reset();
    for (int k = 0; k < N; k++) send(8'(k), 8'(k+1), 1'b0);
    idle(5);
    for (int k = 0; k < N; k++) send(8'(k), 8'd100, 1'b0);
    in_valid = 1'b0;
    frame_ready = 1'b1;
    tick();
    frame_ready = 1'b0;
    chk("sim_valid", 32'(fv[0]), 1);
    chk("sim_ovf", 32'(ovf[0]), 0);
    chk("sim_byte0", 32'(fd[0][7:0]), 32'h64);
    chk("sim_byte99", 32'(fd[0][99*8 +: 8]), 32'hC7);
    idle(5);
    chk("sim_ovf_l3", 32'(ovf[1]), 0);
    frame_ready = 1'b1;
    idle(3);
    chk("sim_drained", 32'(fv[0]), 0);

    // Alternating bubbles, same data as the basic frame.
    fcount[0] = 0; fcount[1] = 0;
    for (int c = 0; c < 2*N; c++) begin
      if (c % 2 == 0) send(8'(c/2), 8'(c), 1'b0);
      else idle(1);
    end
    idle(6);
    for (int i = 0; i < 2; i++) begin
      bit ok;
      chk($sformatf("bub_count[%0d]", i), fcount[i], 1);
      chk($sformatf("bub_mis[%0d]", i), 32'(mcnt[i]), 0);
      ok = 1;
      for (int k = 0; k < N; k++) if (cap[i][k*8 +: 8] !== 8'((3*k) % 256)) ok = 0;
      chk($sformatf("bub_frame[%0d]", i), 32'(ok), 1);
    end

    // Reset in the middle of a frame.
    for (int k = 0; k < 40; k++) send(8'd200, 8'(k), k == 3);
    idle(4);
    chk("mid_mis_before", 32'(mcnt[0]), 1);
    chk("mid_busy_before", 32'(busy[0]), 1);
    reset = 1'b0;
    model_clear();
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("mid_rst_mis[%0d]", i), 32'(mcnt[i]), 0);
      chk($sformatf("mid_rst_ovf[%0d]", i), 32'(ovf[i]), 0);
      chk($sformatf("mid_rst_busy[%0d]", i), 32'(busy[i]), 0);
    end
    tick();
    reset = 1'b1;
    fcount[0] = 0; fcount[1] = 0;
    for (int k = 0; k < N; k++) send(8'(k), 8'(7*k + 1), 1'b0);
    idle(6);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("post_count[%0d]", i), fcount[i], 1);
      chk($sformatf("post_byte0[%0d]", i), 32'(cap[i][7:0]), 32'h01);
      chk($sformatf("post_byte99[%0d]", i), 32'(cap[i][99*8 +: 8]), 32'h19);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
